// File: rtl/fb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fb_ctrl_pkg
// Purpose  : Shared types and helpers for the framebuffer write arbiter:
//            FSM state encoding, requester port ids for the round-robin
//            pointer, and the stored-pixel-count calculation.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fb_ctrl_pkg;

  // Top-level controller states.
  typedef enum logic [0:0] {
    ARB  = 1'b0,
    FILL = 1'b1
  } fb_state_t;

  // Requester identity held in the round-robin "last granted" register.
  typedef enum logic [0:0] {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } fb_port_t;

  // Number of stored pixels: each stored pixel covers a
  // scale x scale block of screen pixels.
  function automatic int unsigned calc_npix(input int unsigned width,
                                            input int unsigned height,
                                            input int unsigned scale);
    return (width / scale) * (height / scale);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : fb_rr_arbiter2
// Purpose  : Two-way round-robin arbiter. With en_i high, a single request
//            is granted directly; simultaneous requests go to the port that
//            was not granted last. The last-granted pointer updates on every
//            grant and resets to PORT_B so that A wins the first tie.
// Ports    : clk    - clock, rising edge
//            rst    - asynchronous active-high reset
//            req_i  - request vector, [0]=A, [1]=B
//            en_i   - grant enable; no grant while low
//            gnt_o  - one-hot grant (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module fb_rr_arbiter2
  import fb_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  fb_port_t rr_last_q;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (rr_last_q == PORT_A) ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_q <= PORT_B;
    end else if (gnt_o[0]) begin
      rr_last_q <= PORT_A;
    end else if (gnt_o[1]) begin
      rr_last_q <= PORT_B;
    end
  end

endmodule
`default_nettype wire

// File: rtl/framebuffer_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : framebuffer_write_arbiter
// Purpose  : Sole owner of the framebuffer write port. Shares it between
//            pixel requesters A and B (round-robin) and a fill sequencer
//            that sweeps every stored pixel with one colour. All writes are
//            registered (accept in t, write strobe in t+1) and stall while
//            the framebuffer reports its own reset in progress.
// Ports    : clk, rst                 - clock / async active-high reset
//            a_valid_i/a_ready_o      - requester A handshake
//            a_addr_i/a_data_i        - requester A write address / pixel
//            b_*                      - same roles for requester B
//            fill_start_i             - pulse: start full-frame fill
//            fill_color_i             - fill pixel, sampled on accepted start
//            fill_busy_o              - fill in progress
//            fb_rst_busy_i            - framebuffer clearing; no writes
//            en_wr_o, wrea_o          - write enable / strobe (identical)
//            addr_wr_o, din_o         - write address / data (hold when idle)
//            stat_a_o/stat_b_o/stat_fill_o - saturating 32-bit counters of
//                                       A grants, B grants and fill writes
//                                       (only with FB_ARB_STATS_EN defined)
// Config   : FB_ARB_STATS_EN - enables the statistics counters and ports
// Revision : 1.0 - initial release
// ============================================================================
module framebuffer_write_arbiter
  import fb_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH    = 640,
  parameter int unsigned FRAME_HEIGHT   = 480,
  parameter int unsigned SCALING_FACTOR = 1,
  parameter int unsigned ADDR_WIDTH     = 19,
  parameter int unsigned DATA_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid_i,
  output logic                  a_ready_o,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  input  logic                  b_valid_i,
  output logic                  b_ready_o,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  input  logic                  fill_start_i,
  input  logic [DATA_WIDTH-1:0] fill_color_i,
  output logic                  fill_busy_o,
  input  logic                  fb_rst_busy_i,
  output logic                  en_wr_o,
  output logic                  wrea_o,
  output logic [ADDR_WIDTH-1:0] addr_wr_o,
  output logic [DATA_WIDTH-1:0] din_o
`ifdef FB_ARB_STATS_EN
  ,
  output logic [31:0]           stat_a_o,
  output logic [31:0]           stat_b_o,
  output logic [31:0]           stat_fill_o
`endif
);

  localparam int unsigned           c_npix      = calc_npix(FRAME_WIDTH, FRAME_HEIGHT,
                                                            SCALING_FACTOR);
  // One extra bit so the range check cannot wrap when NPIX == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0]   c_npix_ext  = (ADDR_WIDTH+1)'(c_npix);
  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(c_npix - 1);

  fb_state_t             state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [DATA_WIDTH-1:0] color_q;
  logic                  en_wr_q;
  logic [ADDR_WIDTH-1:0] addr_wr_q;
  logic [DATA_WIDTH-1:0] din_q;

  logic                  en_wr_d;
  logic [ADDR_WIDTH-1:0] addr_wr_d;
  logic [DATA_WIDTH-1:0] din_d;

  logic [1:0]            w_gnt;
  logic                  w_arb_en;
  logic                  w_fill_issue;
  logic                  w_a_in_range;
  logic                  w_b_in_range;

  // A fill start takes priority over A/B in the same cycle, so the arbiter
  // is disabled whenever a start would be accepted.
  assign w_arb_en     = (state_q == ARB) && !fb_rst_busy_i && !fill_start_i;
  assign w_fill_issue = (state_q == FILL) && !fb_rst_busy_i;
  assign w_a_in_range = ({1'b0, a_addr_i} < c_npix_ext);
  assign w_b_in_range = ({1'b0, b_addr_i} < c_npix_ext);

  fb_rr_arbiter2 u_rr_arbiter (
    .clk   (clk),
    .rst   (rst),
    .req_i ({b_valid_i, a_valid_i}),
    .en_i  (w_arb_en),
    .gnt_o (w_gnt)
  );

  assign a_ready_o   = w_gnt[0];
  assign b_ready_o   = w_gnt[1];
  assign fill_busy_o = (state_q == FILL);

  // Next write-port values. Out-of-range requests are handshaken but
  // produce no write, and address/data keep their previous value.
  always_comb begin
    en_wr_d   = 1'b0;
    addr_wr_d = addr_wr_q;
    din_d     = din_q;
    if (w_gnt[0]) begin
      if (w_a_in_range) begin
        en_wr_d   = 1'b1;
        addr_wr_d = a_addr_i;
        din_d     = a_data_i;
      end
    end else if (w_gnt[1]) begin
      if (w_b_in_range) begin
        en_wr_d   = 1'b1;
        addr_wr_d = b_addr_i;
        din_d     = b_data_i;
      end
    end else if (w_fill_issue) begin
      en_wr_d   = 1'b1;
      addr_wr_d = cnt_q;
      din_d     = color_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB;
      cnt_q     <= '0;
      color_q   <= '0;
      en_wr_q   <= 1'b0;
      addr_wr_q <= '0;
      din_q     <= '0;
    end else begin
      en_wr_q   <= en_wr_d;
      addr_wr_q <= addr_wr_d;
      din_q     <= din_d;
      case (state_q)
        ARB: begin
          if (fill_start_i && !fb_rst_busy_i) begin
            color_q <= fill_color_i;
            cnt_q   <= '0;
            state_q <= FILL;
          end
        end
        FILL: begin
          // fill_start is ignored here; the counter only moves on issued writes.
          if (w_fill_issue) begin
            if (cnt_q == c_last_addr) begin
              cnt_q   <= '0;
              state_q <= ARB;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign en_wr_o   = en_wr_q;
  assign wrea_o    = en_wr_q;
  assign addr_wr_o = addr_wr_q;
  assign din_o     = din_q;

`ifdef FB_ARB_STATS_EN
  logic [31:0] stat_a_q;
  logic [31:0] stat_b_q;
  logic [31:0] stat_fill_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_a_q    <= '0;
      stat_b_q    <= '0;
      stat_fill_q <= '0;
    end else begin
      if (w_gnt[0] && (stat_a_q != '1)) begin
        stat_a_q <= stat_a_q + 32'd1;
      end
      if (w_gnt[1] && (stat_b_q != '1)) begin
        stat_b_q <= stat_b_q + 32'd1;
      end
      if (w_fill_issue && (stat_fill_q != '1)) begin
        stat_fill_q <= stat_fill_q + 32'd1;
      end
    end
  end

  assign stat_a_o    = stat_a_q;
  assign stat_b_o    = stat_b_q;
  assign stat_fill_o = stat_fill_q;
`endif

endmodule
`default_nettype wire
